// File: rtl/toggle_handshake_responder_if.sv
// rtl/toggle_handshake_responder_if.sv - toggle request/ack and consumer dequeue signal bundle
interface toggle_handshake_responder_if #(
    parameter int width = 32
);
    logic             req_toggle;
    logic [width-1:0] req_data;
    logic             ack_toggle;
    logic [width-1:0] out_data;
    logic             out_valid;
    logic             out_deq;
    logic             overrun;

    modport master (
        output req_toggle,
        output req_data,
        output out_deq,
        input  ack_toggle,
        input  out_data,
        input  out_valid,
        input  overrun
    );

    modport slave (
        input  req_toggle,
        input  req_data,
        input  out_deq,
        output ack_toggle,
        output out_data,
        output out_valid,
        output overrun
    );
endinterface

// File: rtl/toggle_handshake_responder.sv
// rtl/toggle_handshake_responder.sv - destination end of toggle CDC handshake with 2-entry buffer
// Optional overrun checker: TOGGLE_HANDSHAKE_RESPONDER_OVERRUN_CHECK_EN
module toggle_handshake_responder #(
    parameter int   width = 32,
    parameter logic init  = 1'b0
) (
    input logic                        CLK,
    input logic                        RST_N,
    toggle_handshake_responder_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             sync1;
    logic             sync2;
    logic             last;
    logic             ack;
    logic             head;
    logic             tail;
    logic [width-1:0] mem [2];

    logic             pending;
    logic             slot_free;
    logic             capture;
    logic             deq;
    logic             valid;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= EMPTY;
            sync1  <= init;
            sync2  <= init;
            last   <= init;
            ack    <= init;
            head   <= 1'b0;
            tail   <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            state <= state_next;
            sync1 <= bus.req_toggle;
            sync2 <= sync1;
            if (capture) begin
                mem[tail] <= bus.req_data;
                tail      <= ~tail;
                last      <= sync2;
                ack       <= ~ack;
            end
            if (deq) begin
                head <= ~head;
            end
        end
    end

    // Simultaneous capture and dequeue leave the occupancy unchanged.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (capture) state_next = ONE;
            ONE: begin
                if (capture && !deq)      state_next = FULL;
                else if (!capture && deq) state_next = EMPTY;
            end
            FULL:  if (deq && !capture) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        valid     = (state != EMPTY);
        pending   = (sync2 != last);
        slot_free = (state != FULL) || bus.out_deq;
        capture   = pending && slot_free;
        deq       = bus.out_deq && valid;
    end

    assign bus.out_valid  = valid;
    assign bus.out_data   = mem[head];
    assign bus.ack_toggle = ack;

`ifdef TOGGLE_HANDSHAKE_RESPONDER_OVERRUN_CHECK_EN
    logic overrun_q;

    // A second toggle behind a stalled one would cancel the edge before capture.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overrun_q <= 1'b0;
        end else if (pending && !capture && (sync1 != sync2)) begin
            overrun_q <= 1'b1;
        end
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = 1'b0;
`endif
endmodule

// File: tb/tb_toggle_handshake_responder.sv
// tb/tb_toggle_handshake_responder.sv - scoreboard bench for toggle_handshake_responder
module tb_toggle_handshake_responder;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   errors  = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;
    logic        src_done;

`ifdef TOGGLE_HANDSHAKE_RESPONDER_OVERRUN_CHECK_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    always #5 clk = ~clk;

    toggle_handshake_responder_if #(.width(32)) bus_if ();

    toggle_handshake_responder #(.width(32), .init(1'b0)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] word);
        exp_q.push_back(word);
        bus_if.req_data   = word;
        bus_if.req_toggle = ~bus_if.req_toggle;
    endtask

    task automatic wait_ack(input int budget);
        int n = 0;
        while (bus_if.ack_toggle !== bus_if.req_toggle && n < budget) begin
            tick();
            n++;
        end
        if (bus_if.ack_toggle !== bus_if.req_toggle) begin
            vectors++;
            errors++;
            $display("FAIL ack_timeout: got %b expected %b", bus_if.ack_toggle, bus_if.req_toggle);
        end
    endtask

    task automatic drain();
        bus_if.out_deq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!bus_if.out_valid) break;
        end
        bus_if.out_deq = 1'b0;
        check("drain_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("drain_queue_empty", exp_q.size(), 32'd0);
    endtask

    // Pops the expected word whenever the consumer actually dequeues.
    always @(negedge clk) begin
        #2;
        if (rst_n && bus_if.out_deq && bus_if.out_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_word: got %h expected none", bus_if.out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("fifo_data", bus_if.out_data, mon_exp);
            end
        end
    end

    initial begin
        rst_n             = 1'b0;
        bus_if.req_toggle = 1'b0;
        bus_if.req_data   = '0;
        bus_if.out_deq    = 1'b0;
        src_done          = 1'b0;
        tick();
        tick();
        check("rst_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("rst_ack", {31'd0, bus_if.ack_toggle}, 32'd0);
        check("rst_overrun", {31'd0, bus_if.overrun}, 32'd0);
        check("rst_data", bus_if.out_data, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single transfer and latency
        send(32'hA5A5_0001);
        tick();
        tick();
        check("lat_valid_early", {31'd0, bus_if.out_valid}, 32'd0);
        check("lat_ack_early", {31'd0, bus_if.ack_toggle}, 32'd0);
        tick();
        check("single_valid", {31'd0, bus_if.out_valid}, 32'd1);
        check("single_data", bus_if.out_data, 32'hA5A5_0001);
        check("single_ack", {31'd0, bus_if.ack_toggle}, 32'd1);
        bus_if.out_deq = 1'b1;
        tick();
        bus_if.out_deq = 1'b0;
        check("single_deq_valid", {31'd0, bus_if.out_valid}, 32'd0);

        // Backpressure: third request stalls until a slot frees
        send(32'h1);
        wait_ack(20);
        send(32'h2);
        wait_ack(20);
        send(32'h3);
        repeat (6) tick();
        check("bp_ack_held", {31'd0, bus_if.ack_toggle}, 32'd1);
        check("bp_head", bus_if.out_data, 32'h1);
        bus_if.out_deq = 1'b1;
        tick();
        bus_if.out_deq = 1'b0;
        check("bp_ack_on_deq", {31'd0, bus_if.ack_toggle}, 32'd0);
        drain();

        // Capture and dequeue together while holding one word
        send(32'h10);
        wait_ack(20);
        send(32'h20);
        tick();
        tick();
        bus_if.out_deq = 1'b1;
        tick();
        bus_if.out_deq = 1'b0;
        check("simul_valid", {31'd0, bus_if.out_valid}, 32'd1);
        check("simul_data", bus_if.out_data, 32'h20);
        check("simul_ack", {31'd0, bus_if.ack_toggle}, 32'd0);
        bus_if.out_deq = 1'b1;
        tick();
        bus_if.out_deq = 1'b0;
        check("simul_one_left", {31'd0, bus_if.out_valid}, 32'd0);
        check("simul_queue", exp_q.size(), 32'd0);

        // Randomized traffic with random consumer backpressure
        fork
            begin
                repeat (60) begin
                    wait_ack(200);
                    repeat ($urandom_range(0, 3)) tick();
                    send($urandom);
                end
                wait_ack(200);
                src_done = 1'b1;
            end
            begin
                while (!src_done) begin
                    bus_if.out_deq = 1'($urandom_range(0, 1));
                    tick();
                end
                bus_if.out_deq = 1'b0;
            end
        join
        drain();

        // Reset while full with a request pending
        send(32'hB000_0001);
        wait_ack(20);
        send(32'hB000_0002);
        wait_ack(20);
        send(32'hB000_0003);
        repeat (4) tick();
        check("mid_full_valid", {31'd0, bus_if.out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("async_rst_ack", {31'd0, bus_if.ack_toggle}, 32'd0);
        check("async_rst_overrun", {31'd0, bus_if.overrun}, 32'd0);
        check("async_rst_data", bus_if.out_data, 32'd0);
        exp_q.delete();
        bus_if.req_toggle = 1'b0;
        send(32'hC0DE_0001);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_valid", {31'd0, bus_if.out_valid}, 32'd1);
        check("post_rst_data", bus_if.out_data, 32'hC0DE_0001);
        check("post_rst_ack", {31'd0, bus_if.ack_toggle}, 32'd1);
        drain();

        // Protocol violation: double toggle while full
        send(32'hD000_0001);
        wait_ack(20);
        send(32'hD000_0002);
        wait_ack(20);
        check("ovr_clear", {31'd0, bus_if.overrun}, 32'd0);
        bus_if.req_data   = 32'hDEAD_BEEF;
        bus_if.req_toggle = ~bus_if.req_toggle;
        tick();
        bus_if.req_toggle = ~bus_if.req_toggle;
        repeat (4) tick();
        check("ovr_set", {31'd0, bus_if.overrun}, {31'd0, EXP_OVR});
        drain();
        send(32'hD000_0003);
        wait_ack(20);
        drain();
        check("ovr_sticky", {31'd0, bus_if.overrun}, {31'd0, EXP_OVR});
        rst_n = 1'b0;
        tick();
        check("ovr_rst", {31'd0, bus_if.overrun}, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
